// File: rtl/fifo_sync_core.sv
// fifo_sync_core: single-clock FIFO with occupancy count and overflow/underflow pulses
//   clk, rst_a (async, active-low)
//   data_in/wr_en    : write side, word stored when the write is accepted
//   rd_en/data_out   : read side, data_out registered one cycle after an accepted read
//   full/empty/count : registered status, consistent with each other every cycle
//   overflow/underflow : one-cycle pulse after a rejected write/read
module fifo_sync_core #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_a,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            data_out,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_acc, rd_acc;
  always_comb begin
    rd_acc      = rd_en & ~empty_q;
    // a read in the same cycle frees the slot, so a full FIFO still takes the write
    wr_acc      = wr_en & (~full_q | rd_acc);
    wr_ptr_d    = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = (wr_acc & ~rd_acc) ? count_q + 1'b1 :
                  (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
    data_out_d  = rd_acc ? mem[rd_ptr_q] : data_out_q;
    full_d      = count_d == FULL_CNT;
    empty_d     = count_d == '0;
    overflow_d  = wr_en & ~wr_acc;
    underflow_d = rd_en & ~rd_acc;
  end
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  // storage is not reset; pointers returning to zero make stale words unreachable
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  assign data_out  = data_out_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_fifo_sync_core.sv
// tb_fifo_sync_core: directed self-checking bench for fifo_sync_core (DEPTH=8, DATA_W=4)
module tb_fifo_sync_core;
  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic [3:0] data_in = '0;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0] data_out;
  logic       full, empty, overflow, underflow;
  logic [3:0] count;
  int total = 0, bad = 0;
  fifo_sync_core #(.DATA_W(4), .DEPTH(8)) dut (
    .clk(clk), .rst_a(rst_a), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_status(input string tag, input int c, input logic e, input logic f);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(f));
  endtask
  initial begin
    repeat (2) tick();
    chk_status("in_reset", 0, 1, 0);
    rst_a = 1'b1;
    repeat (3) tick();
    chk_status("idle", 0, 1, 0);
    chk("idle.data_out", 32'(data_out), 0);
    chk("idle.overflow", 32'(overflow), 0);
    chk("idle.underflow", 32'(underflow), 0);
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_in = 4'(i);
      tick();
      chk_status($sformatf("fill%0d", i), i, 0, i == 8);
    end
    data_in = 4'hA;
    tick();
    chk("ovf.pulse", 32'(overflow), 1);
    chk_status("ovf", 8, 0, 1);
    wr_en = 1'b0;
    tick();
    chk("ovf.clear", 32'(overflow), 0);
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("drain%0d.data", i), 32'(data_out), 32'(i));
      chk_status($sformatf("drain%0d", i), 8 - i, i == 8, 0);
      chk($sformatf("drain%0d.underflow", i), 32'(underflow), 0);
    end
    tick();
    chk("udf.pulse", 32'(underflow), 1);
    chk("udf.hold", 32'(data_out), 8);
    chk_status("udf", 0, 1, 0);
    rd_en = 1'b0;
    tick();
    chk("udf.clear", 32'(underflow), 0);
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 4'(9 + i);
      tick();
    end
    wr_en = 1'b0;
    chk_status("wrapA.fill", 6, 0, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("wrapA.rd%0d", i), 32'(data_out), 32'(9 + i));
    end
    rd_en = 1'b0;
    chk_status("wrapA.done", 0, 1, 0);
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 4'(3 + i);
      tick();
    end
    wr_en = 1'b0;
    chk_status("wrapB.fill", 5, 0, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("wrapB.rd%0d", i), 32'(data_out), 32'(3 + i));
    end
    rd_en = 1'b0;
    chk_status("wrapB.done", 0, 1, 0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 4'h5;
    tick();
    chk_status("rw_empty", 1, 0, 0);
    chk("rw_empty.underflow", 32'(underflow), 1);
    chk("rw_empty.data_hold", 32'(data_out), 7);
    rd_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_in = 4'(6 + i);
      tick();
    end
    chk_status("refill", 8, 0, 1);
    rd_en = 1'b1;
    data_in = 4'hF;
    tick();
    chk_status("rw_full", 8, 0, 1);
    chk("rw_full.data", 32'(data_out), 5);
    chk("rw_full.overflow", 32'(overflow), 0);
    chk("rw_full.underflow", 32'(underflow), 0);
    tick();
    chk("rw_full2.data", 32'(data_out), 6);
    chk_status("rw_full2", 8, 0, 1);
    #2 rst_a = 1'b0;
    #1;
    chk_status("mid_reset", 0, 1, 0);
    chk("mid_reset.data_out", 32'(data_out), 0);
    chk("mid_reset.overflow", 32'(overflow), 0);
    chk("mid_reset.underflow", 32'(underflow), 0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    rd_en = 1'b1;
    tick();
    chk("post_reset.underflow", 32'(underflow), 1);
    chk_status("post_reset", 0, 1, 0);
    rd_en = 1'b0;
    wr_en = 1'b1;
    data_in = 4'h3;
    tick();
    wr_en = 1'b0;
    chk_status("post_reset.wr", 1, 0, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_reset.rd", 32'(data_out), 3);
    chk_status("post_reset.rd", 0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_sync_core.md
Name: fifo_sync_core

Overview:
Synchronous single-clock FIFO. This is the storage end of the fifo_inf write/read interface: it accepts writes from the driver side (data_in, wr_en) and serves reads (rd_en, data_out), reporting full/empty status. The testbench driver and monitor clocking blocks sample its outputs on posedge clk. It adds an occupancy count and overflow/underflow error pulses for scoreboarding.

Parameters:
DATA_W, 4, data word width; matches the 4-bit data_in/data_out of fifo_inf.
DEPTH, 8, number of entries; power of two, minimum 2.
ADDR_W, $clog2(DEPTH), derived localparam for pointer width; not overridable.

Ports:
clk  input  1  single clock; all state changes on posedge clk.
rst_a  input  1  asynchronous reset, active-low.
data_in  input  DATA_W  write data; sampled when a write is accepted.
wr_en  input  1  write request.
rd_en  input  1  read request.
data_out  output  DATA_W  registered read data.
full  output  1  high when count == DEPTH.
empty  output  1  high when count == 0.
count  output  ADDR_W+1  current occupancy, 0..DEPTH.
overflow  output  1  one-cycle pulse after a rejected write.
underflow  output  1  one-cycle pulse after a rejected read.

Behaviour:
- Reset (rst_a low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0, overflow=0, underflow=0.
- Storage array is not reset. Its contents are unreachable after reset because the pointers return to 0.
- Reset asserted mid-operation discards all queued entries immediately. The first edge after deassertion behaves as an empty FIFO.
- Write acceptance: wr_acc = wr_en & (~full | rd_acc).
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Read acceptance: rd_acc = rd_en & ~empty.
- On rd_acc: data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
- When no read is accepted, data_out holds its previous value.
- Read latency: data is visible on data_out the cycle after the rd_en edge at which it was accepted (1 cycle).
- No write-to-read bypass. A word written at edge N is readable no earlier than a read accepted at edge N+1.
- Simultaneous wr_en & rd_en:
  - Not empty and not full: both accepted; count unchanged.
  - Full: both accepted (the read frees the slot); count stays DEPTH and full stays 1.
  - Empty: write accepted, read rejected (underflow pulses); count becomes 1.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged otherwise. count never exceeds DEPTH and never goes below 0.
- full and empty are registered. They are derived from the next count value, so they are consistent with count in the same cycle.
- overflow <= wr_en & ~wr_acc. A write while full without an accompanying accepted read is dropped; the array and wr_ptr are untouched.
- underflow <= rd_en & ~rd_acc. A read while empty is ignored; rd_ptr and data_out are unchanged.
- overflow and underflow are one-cycle pulses, not sticky. They reassert every cycle the illegal request persists.
- X on wr_en/rd_en is out of contract. Inputs are assumed driven via the driver_cb clocking block (skewed off posedge).

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, count=0, data_out=0, overflow=0, underflow=0.
- Write 1,2,...,8 on consecutive cycles (DEPTH=8) -> count steps 1..8. full=1 after the 8th edge; empty drops after the 1st edge.
- Write 4'hA while full -> overflow=1 for exactly one cycle, count stays 8. A following drain returns 1..8 in order with no 4'hA.
- Drain 8 reads then one extra read -> data_out 1..8, each one cycle after its read edge. empty=1 after the 8th read. The extra read gives underflow=1 for one cycle and data_out holds 8.
- Wrap-around: write 6, read 6, write 5, read 5 with data 3,4,5,6,7 -> pointers wrap past 7, reads return 3..7 in order, count returns to 0.
- Simultaneous wr_en=rd_en=1:
  - When full: count stays 8, full stays 1, oldest word appears on data_out.
  - When empty: count becomes 1, underflow=1.
  - Then assert rst_a=0 mid-burst: outputs return to reset values immediately.
